// File: rtl/uart_receiver.sv
// ============================================================================
// Module     : uart_receiver
// Description: 8N1 UART receiver with mid-bit sampling, glitch rejection and
//              framing-error detection; waits for the line to return high
//              after a bad stop bit.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module uart_receiver #(
  parameter int CYCLES_PER_BIT = 22274
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_framing_error,
  output logic       o_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CYCLES_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        half_hit;
  logic        bit_hit;

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);
  assign o_busy   = (state != IDLE);

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (half_hit) state_next = rx_s ? IDLE : DATA;
      DATA:      if (bit_hit && (bit_idx == 3'd7)) state_next = STOP;
      STOP:      if (bit_hit) state_next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bit timer restarts on every state change so each phase is measured
  // from its own entry point.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= 16'd0;
    end else if ((state_next != state) || (state == IDLE) ||
                 (state == WAIT_HIGH) || bit_hit) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      bit_idx         <= 3'd0;
      shift_reg       <= 8'h00;
      o_data          <= 8'h00;
      o_valid         <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      o_valid         <= 1'b0;
      o_framing_error <= 1'b0;
      if ((state == START) && half_hit) begin
        bit_idx <= 3'd0;
      end
      if ((state == DATA) && bit_hit) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 3'd1;
      end
      // Output byte only moves on a good stop bit.
      if ((state == STOP) && bit_hit) begin
        if (rx_s) begin
          o_data  <= shift_reg;
          o_valid <= 1'b1;
        end else begin
          o_framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module     : tb_uart_receiver
// Description: Directed self-checking bench for uart_receiver (16 cycles/bit).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_framing_error;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  int         valid_cnt   = 0;
  int         fe_cnt      = 0;
  int         both_cnt    = 0;
  int         data_glitch = 0;
  logic [7:0] prev_data   = 8'h00;
  logic [7:0] rx_q[$];

  uart_receiver #(.CYCLES_PER_BIT(CPB)) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_rx            (i_rx),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_framing_error (o_framing_error),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  // Pulse/data observer, sampled on the inactive edge.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      rx_q.push_back(o_data);
    end
    if (o_framing_error === 1'b1) fe_cnt = fe_cnt + 1;
    if ((o_valid === 1'b1) && (o_framing_error === 1'b1)) both_cnt = both_cnt + 1;
    if ((i_reset === 1'b0) && (o_valid !== 1'b1) && (o_data !== prev_data))
      data_glitch = data_glitch + 1;
    prev_data = o_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] partial;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  32'(o_data), 32'h00);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_fe",    32'(o_framing_error), 32'h0);
    check("reset_busy",  32'(o_busy), 32'h0);
    i_reset = 1'b0;
    idle(10);

    // Plain frame
    send_frame(8'hA5, 1'b1);
    idle(4);
    check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    check("a5_data",      32'(o_data), 32'hA5);
    check("a5_fe_cnt",    32'(fe_cnt), 32'd0);
    check("a5_busy",      32'(o_busy), 32'h0);

    // Short low glitch must be rejected at the start-bit midpoint
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    check("glitch_valid_cnt", 32'(valid_cnt), 32'd1);
    check("glitch_fe_cnt",    32'(fe_cnt), 32'd0);
    check("glitch_busy",      32'(o_busy), 32'h0);
    send_frame(8'h3C, 1'b1);
    idle(4);
    check("3c_valid_cnt", 32'(valid_cnt), 32'd2);
    check("3c_data",      32'(o_data), 32'h3C);

    // Bad stop bit followed by a long break
    send_frame(8'h5A, 1'b0);
    i_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("break_fe_cnt",    32'(fe_cnt), 32'd1);
    check("break_valid_cnt", 32'(valid_cnt), 32'd2);
    check("break_data_held", 32'(o_data), 32'h3C);
    check("break_busy",      32'(o_busy), 32'h1);
    idle(20);
    check("break_end_busy",  32'(o_busy), 32'h0);
    send_frame(8'h81, 1'b1);
    idle(4);
    check("81_valid_cnt", 32'(valid_cnt), 32'd3);
    check("81_data",      32'(o_data), 32'h81);
    check("81_fe_cnt",    32'(fe_cnt), 32'd1);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd5);
    check("b2b_first",     32'(rx_q[3]), 32'h00);
    check("b2b_second",    32'(rx_q[4]), 32'hFF);

    // Reset during data bit 4
    partial = 8'h55;
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = partial[4];
    repeat (CPB / 2) @(negedge clk);
    check("mid_busy", 32'(o_busy), 32'h1);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_data",  32'(o_data), 32'h00);
    check("async_rst_busy",  32'(o_busy), 32'h0);
    check("async_rst_valid", 32'(o_valid), 32'h0);
    check("async_rst_fe",    32'(o_framing_error), 32'h0);
    i_rx = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    idle(3 * CPB);
    check("post_rst_valid_cnt", 32'(valid_cnt), 32'd5);
    check("post_rst_fe_cnt",    32'(fe_cnt), 32'd1);
    send_frame(8'h7E, 1'b1);
    idle(4);
    check("7e_valid_cnt", 32'(valid_cnt), 32'd6);
    check("7e_data",      32'(o_data), 32'h7E);

    // Continuous stream of every byte value
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
    idle(4);
    check("stream_valid_cnt", 32'(valid_cnt), 32'd262);
    for (int i = 0; i < 256; i++) begin
      if (rx_q.size() > 6 + i) check($sformatf("stream_byte_%0d", i), 32'(rx_q[6 + i]), 32'(i));
    end
    check("stream_fe_cnt",      32'(fe_cnt), 32'd1);
    check("never_both_pulses",  32'(both_cnt), 32'd0);
    check("data_only_on_valid", 32'(data_glitch), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
